// File: rtl/fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_unit_arbiter
//  Purpose  : Round-robin arbiter that shares one pipelined 32-bit
//             floating-point unit between NREQ requesters. Each accepted
//             operand pair carries its requester ID through a tag pipeline
//             matching the unit latency, so the result is routed back to
//             the requester that issued it.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   system clock, rising edge
//    rst_n         in   asynchronous active-low reset
//    i_req_valid   in   [NREQ]      requester i has an operand pair pending
//    i_req_a       in   [32*NREQ]   operand A, requester i at [32i+31:32i]
//    i_req_b       in   [32*NREQ]   operand B, packed like i_req_a
//    o_req_ready   out  [NREQ]      one-hot combinational grant
//    i_hold        in   blocks new grants; in-flight ops still complete
//    o_fpu_a       out  [32]        registered operand A to the shared unit
//    o_fpu_b       out  [32]        registered operand B to the shared unit
//    i_fpu_value   in   [32]        result from the shared unit
//    o_resp_valid  out  [NREQ]      one-hot, one cycle per returned result
//    o_resp_value  out  [32]        registered result
//    o_busy        out  one or more operations in flight
// ============================================================================
module fp_unit_arbiter #(
  parameter int NREQ    = 4,
  parameter int FPU_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [32*NREQ-1:0]   i_req_a,
  input  logic [32*NREQ-1:0]   i_req_b,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic                 i_hold,
  output logic [31:0]          o_fpu_a,
  output logic [31:0]          o_fpu_b,
  input  logic [31:0]          i_fpu_value,
  output logic [NREQ-1:0]      o_resp_valid,
  output logic [31:0]          o_resp_value,
  output logic                 o_busy
);

  localparam int                c_idw  = $clog2(NREQ);
  localparam logic [c_idw:0]    c_nreq = (c_idw+1)'(NREQ);
  localparam logic [c_idw-1:0]  c_last = c_idw'(NREQ-1);

  logic [c_idw-1:0]  r_ptr;
  logic [NREQ-1:0]   r_outstanding;
  logic [FPU_LAT-1:0] r_tag_vld;
  logic [c_idw-1:0]  r_tag_id [FPU_LAT];
  logic [31:0]       r_fpu_a;
  logic [31:0]       r_fpu_b;
  logic [NREQ-1:0]   r_resp_valid;
  logic [31:0]       r_resp_value;

  logic [NREQ-1:0]   w_elig;
  logic              w_found;
  logic [c_idw-1:0]  w_gnt_id;
  logic [c_idw:0]    w_sum;
  logic [c_idw-1:0]  w_idx;
  logic [31:0]       w_sel_a;
  logic [31:0]       w_sel_b;
  logic              w_done;
  logic [c_idw-1:0]  w_done_id;
  logic [NREQ-1:0]   w_out_nxt;

  // A requester with a result still in the unit may not issue again.
  assign w_elig = i_req_valid & ~r_outstanding & {NREQ{~i_hold}};

  // Scan from the pointer, wrapping modulo NREQ; the extra bit in w_sum
  // lets ptr+k exceed NREQ-1 before being folded back.
  always_comb begin
    w_found     = 1'b0;
    w_gnt_id    = '0;
    w_sum       = '0;
    w_idx       = '0;
    o_req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (c_idw+1)'(k);
      if (w_sum >= c_nreq) w_sum = w_sum - c_nreq;
      w_idx = w_sum[c_idw-1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (w_found) o_req_ready[w_gnt_id] = 1'b1;
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == c_idw'(i)) begin
        w_sel_a = i_req_a[i*32 +: 32];
        w_sel_b = i_req_b[i*32 +: 32];
      end
    end
  end

  assign w_done    = r_tag_vld[FPU_LAT-1];
  assign w_done_id = r_tag_id[FPU_LAT-1];

  // Completing and newly accepted requesters are always distinct, since the
  // completing one is still outstanding this cycle and thus not eligible.
  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_done)  w_out_nxt[w_done_id] = 1'b0;
    if (w_found) w_out_nxt[w_gnt_id]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_outstanding <= '0;
      r_tag_vld     <= '0;
      for (int s = 0; s < FPU_LAT; s++) r_tag_id[s] <= '0;
      r_fpu_a       <= '0;
      r_fpu_b       <= '0;
      r_resp_valid  <= '0;
      r_resp_value  <= '0;
    end else begin
      r_tag_vld[0] <= w_found;
      r_tag_id[0]  <= w_gnt_id;
      for (int s = 1; s < FPU_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end

      if (w_found) begin
        r_fpu_a <= w_sel_a;
        r_fpu_b <= w_sel_b;
        r_ptr   <= (w_gnt_id == c_last) ? '0 : w_gnt_id + 1'b1;
      end

      r_resp_valid <= '0;
      if (w_done) begin
        r_resp_valid[w_done_id] <= 1'b1;
        r_resp_value            <= i_fpu_value;
      end

      r_outstanding <= w_out_nxt;
    end
  end

  assign o_fpu_a      = r_fpu_a;
  assign o_fpu_b      = r_fpu_b;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_value = r_resp_value;
  assign o_busy       = |r_tag_vld;

endmodule
`default_nettype wire

// File: tb/tb_fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_unit_arbiter
//  Purpose  : Scoreboard bench for fp_unit_arbiter with an adder model of
//             the shared floating-point unit (integer-valued operands only).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_unit_arbiter;

  localparam int NREQ    = 4;
  localparam int FPU_LAT = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                hold = 1'b0;
  logic [31:0]         fpu_a, fpu_b, fpu_value;
  logic [NREQ-1:0]     resp_valid;
  logic [31:0]         resp_value;
  logic                busy;

  int ia [NREQ];
  int ib [NREQ];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] val;
    int          due;
  } exp_t;
  exp_t sb[$];

  int          cyc = 0;
  int          m_ptr = 0;
  logic [31:0] m_fa = '0;
  logic [31:0] m_fb = '0;

  fp_unit_arbiter #(.NREQ(NREQ), .FPU_LAT(FPU_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_req_ready  (req_ready),
    .i_hold       (hold),
    .o_fpu_a      (fpu_a),
    .o_fpu_b      (fpu_b),
    .i_fpu_value  (fpu_value),
    .o_resp_valid (resp_valid),
    .o_resp_value (resp_value),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] int_to_fp32(input int v);
    logic [31:0] m;
    logic        s;
    int          p;
    if (v == 0) return 32'd0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    p = 0;
    for (int k = 0; k < 32; k++) if (m[k]) p = k;
    return {s, 8'(p + 127), 23'(m << (23 - p))};
  endfunction

  function automatic int fp32_to_int(input logic [31:0] f);
    int          e;
    int          mag;
    logic [31:0] m;
    if (f[30:23] == 8'd0) return 0;
    e   = int'(f[30:23]) - 127;
    m   = {8'd0, 1'b1, f[22:0]};
    mag = int'(m >> (23 - e));
    return f[31] ? -mag : mag;
  endfunction

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = int_to_fp32(ia[i]);
      req_b[i*32 +: 32] = int_to_fp32(ib[i]);
    end
  end

  // Shared unit: a+b, one register stage so the result is sampled two
  // edges after the operands are registered.
  logic [31:0] fpu_pipe = '0;
  always @(posedge clk) fpu_pipe <= int_to_fp32(fp32_to_int(fpu_a) + fp32_to_int(fpu_b));
  assign fpu_value = fpu_pipe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_outstanding(input int id);
    foreach (sb[n]) if (sb[n].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor / reference model, evaluated mid-cycle.
  initial begin
    logic [NREQ-1:0] exp_gnt;
    int              g;
    int              idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_value", resp_value, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_fpu_b", fpu_b, 32'd0);
        sb.delete();
        m_ptr = 0;
        m_fa  = '0;
        m_fb  = '0;
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          chk("resp_valid", 32'(resp_valid), 32'(1 << sb[0].id));
          chk("resp_value", resp_value, sb[0].val);
          void'(sb.pop_front());
        end else begin
          chk("resp_idle", 32'(resp_valid), 32'd0);
        end
        chk("busy", 32'(busy), 32'(sb.size() != 0));
        chk("fpu_a", fpu_a, m_fa);
        chk("fpu_b", fpu_b, m_fb);

        exp_gnt = '0;
        g = -1;
        if (!hold) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx] && !is_outstanding(idx)) g = idx;
          end
        end
        if (g >= 0) exp_gnt[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_gnt));

        if (g >= 0) begin
          sb.push_back('{id: g, val: int_to_fp32(ia[g] + ib[g]), due: cyc + FPU_LAT + 1});
          m_ptr = (g + 1) % NREQ;
          m_fa  = int_to_fp32(ia[g]);
          m_fb  = int_to_fp32(ib[g]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ia[i] = 0;
      ib[i] = 0;
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single issue: 1000 + -10 = 990.
    ia[0] = 1000; ib[0] = -10;
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    tick(5);

    // All four requesters with 32 + 32.
    for (int i = 0; i < NREQ; i++) begin
      ia[i] = 32; ib[i] = 32;
    end
    req_valid = 4'b1111;
    tick(4);
    req_valid = '0;
    tick(6);

    // Requester 2 held valid continuously.
    ia[2] = 7; ib[2] = 5;
    req_valid = 4'b0100;
    tick(10);
    req_valid = '0;
    tick(5);

    // Pointer now at 3: requesters 0 and 3 contend, then 1 and 3.
    req_valid = 4'b1001;
    tick(2);
    req_valid = 4'b1010;
    tick(6);
    req_valid = '0;
    tick(5);

    // Two ops in flight, then hold.
    ia[0] = 100; ib[0] = 23; ia[1] = -50; ib[1] = 8;
    req_valid = 4'b0011;
    tick(2);
    hold = 1'b1;
    req_valid = 4'b1111;
    tick(5);
    hold = 1'b0;
    req_valid = '0;
    tick(4);

    // Reset one cycle after an accept.
    ia[0] = 300; ib[0] = 400;
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fpu_a", fpu_a, 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        ia[i] = int'($urandom_range(0, 2000)) - 1000;
        ib[i] = int'($urandom_range(0, 2000)) - 1000;
      end
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      hold      = ($urandom_range(0, 9) == 0);
      tick(1);
    end
    req_valid = '0;
    hold = 1'b0;
    tick(6);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
